// File: rtl/alu_control_unit.sv
// Sequencing controller for the add/sub, Booth multiply and restoring divide datapath.
// Drives the datapath strobes c0..c7 from state and uses the datapath status bits to pick each step.
//
// state     | meaning
// IDLE      | waiting for start
// LOAD_M/Q  | load x into M, then y into Q
// M_*       | Booth step: test pair, add/sub M, arithmetic right shift
// D_*       | restoring step: left shift, trial subtract, test sign, restore
// DONE      | result on z, one-cycle done pulse
module alu_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] in,
    input  logic       cnt_done,
    input  logic       q0,
    input  logic       qm1,
    input  logic       a7,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c5,
    output logic       c6,
    output logic       c7,
    output logic [1:0] op_q,
    output logic       sel_in,
    output logic       busy,
    output logic       done,
    output logic       div_err,
    output logic       q_lsb
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD_M    = 4'd1;
    localparam logic [3:0] S_LOAD_Q    = 4'd2;
    localparam logic [3:0] S_M_TEST    = 4'd3;
    localparam logic [3:0] S_M_SUB     = 4'd4;
    localparam logic [3:0] S_M_ADD     = 4'd5;
    localparam logic [3:0] S_M_SHIFT   = 4'd6;
    localparam logic [3:0] S_D_SHIFT   = 4'd7;
    localparam logic [3:0] S_D_SUB     = 4'd8;
    localparam logic [3:0] S_D_TEST    = 4'd9;
    localparam logic [3:0] S_D_RESTORE = 4'd10;
    localparam logic [3:0] S_DONE      = 4'd11;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       qbit;
    logic       last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            op_q    <= 2'b00;
            div_err <= 1'b0;
            qbit    <= 1'b0;
            last    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        div_err <= 1'b0;
                        qbit    <= 1'b0;
                    end
                end
                S_LOAD_M: begin
                    if (op_q == 2'b11 && in == 8'd0) begin
                        div_err <= 1'b1;
                    end
                end
                S_D_SHIFT: last <= cnt_done;
                S_D_TEST:  qbit <= ~a7;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      state_nxt = start ? S_LOAD_M : S_IDLE;
            S_LOAD_M:    state_nxt = S_LOAD_Q;
            S_LOAD_Q: begin
                if (!op_q[1] || div_err) begin
                    state_nxt = S_DONE;
                end else if (op_q[0]) begin
                    state_nxt = S_D_SHIFT;
                end else begin
                    state_nxt = S_M_TEST;
                end
            end
            S_M_TEST: begin
                case ({q0, qm1})
                    2'b10:   state_nxt = S_M_SUB;
                    2'b01:   state_nxt = S_M_ADD;
                    default: state_nxt = S_M_SHIFT;
                endcase
            end
            S_M_SUB:     state_nxt = S_M_SHIFT;
            S_M_ADD:     state_nxt = S_M_SHIFT;
            S_M_SHIFT:   state_nxt = cnt_done ? S_DONE : S_M_TEST;
            S_D_SHIFT:   state_nxt = S_D_SUB;
            S_D_SUB:     state_nxt = S_D_TEST;
            S_D_TEST: begin
                if (a7) begin
                    state_nxt = S_D_RESTORE;
                end else begin
                    state_nxt = last ? S_DONE : S_D_SHIFT;
                end
            end
            S_D_RESTORE: state_nxt = last ? S_DONE : S_D_SHIFT;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // c6 is the shift-in bit: sign of A for Booth, previous quotient bit for divide.
    always_comb begin
        c0     = 1'b0;
        c1     = 1'b0;
        c2     = 1'b0;
        c3     = 1'b0;
        c4     = 1'b0;
        c5     = 1'b0;
        c6     = 1'b0;
        c7     = 1'b0;
        sel_in = 1'b0;
        done   = 1'b0;
        q_lsb  = 1'b0;
        case (state)
            S_LOAD_M: c0 = 1'b1;
            S_LOAD_Q: begin
                c1     = 1'b1;
                sel_in = 1'b1;
            end
            S_M_SUB: begin
                c2 = 1'b1;
                c3 = 1'b1;
            end
            S_M_ADD: c2 = 1'b1;
            S_M_SHIFT: begin
                c4 = 1'b1;
                c5 = 1'b1;
                c6 = a7;
            end
            S_D_SHIFT: begin
                c4 = 1'b1;
                c5 = 1'b1;
                c6 = qbit;
            end
            S_D_SUB: begin
                c2 = 1'b1;
                c3 = 1'b1;
            end
            S_D_RESTORE: c2 = 1'b1;
            S_DONE: begin
                done  = 1'b1;
                c7    = ~div_err;
                c3    = (op_q == 2'b01);
                q_lsb = qbit;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: a strobe-driven datapath model feeds the status bits, and a
// scoreboard compares each completed operation against plain arithmetic results and cycle counts.
module tb_alu_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] in_bus;
    logic       cnt_done, q0, qm1, a7;
    logic       c0, c1, c2, c3, c4, c5, c6, c7;
    logic [1:0] op_q;
    logic       sel_in, busy, done, div_err, q_lsb;

    always #5 clk = ~clk;

    alu_control_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in(in_bus),
        .cnt_done(cnt_done), .q0(q0), .qm1(qm1), .a7(a7),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
        .op_q(op_q), .sel_in(sel_in), .busy(busy), .done(done),
        .div_err(div_err), .q_lsb(q_lsb)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Datapath model: registers M, A, Q, q(-1) and a shift counter, driven by the strobes.
    logic [7:0] m_r = 8'd0, a_r = 8'd0, q_r = 8'd0;
    logic       qm1_r = 1'b0;
    logic [3:0] cnt_r = 4'd0;
    logic [7:0] cur_x = 8'd0, cur_y = 8'd0;
    logic [15:0] z;

    assign in_bus   = sel_in ? cur_y : cur_x;
    assign q0       = q_r[0];
    assign qm1      = qm1_r;
    assign a7       = a_r[7];
    assign cnt_done = (cnt_r == 4'd7);

    always @(posedge clk) begin
        if (c0) m_r <= in_bus;
        if (c1) begin
            q_r   <= in_bus;
            a_r   <= 8'd0;
            qm1_r <= 1'b0;
            cnt_r <= 4'd0;
        end
        if (c2) a_r <= c3 ? a_r - m_r : a_r + m_r;
        if (c4) begin
            if (op_q == 2'b10) begin
                a_r   <= {c6, a_r[7:1]};
                q_r   <= {a_r[0], q_r[7:1]};
                qm1_r <= q_r[0];
            end else begin
                a_r <= {a_r[6:0], q_r[7]};
                q_r <= {q_r[6:0], c6};
            end
        end
        if (c5) cnt_r <= cnt_r + 4'd1;
    end

    always_comb begin
        z = 16'd0;
        if (op_q[1]) z = {a_r, q_r};
        else if (c3) z = {{8{q_r[7]}}, q_r} - {{8{m_r[7]}}, m_r};
        else         z = {{8{q_r[7]}}, q_r} + {{8{m_r[7]}}, m_r};
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] z;
        logic        err;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference: arithmetic results plus cycle counts derived from Booth pairs / long division.
    function automatic exp_t model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                   input int now);
        exp_t e;
        int   lat, px, py, r, xi, yi;
        logic prev;
        e.op  = o;
        e.err = 1'b0;
        e.z   = 16'd0;
        lat   = 3;
        px    = $signed(x);
        py    = $signed(y);
        xi    = int'(x);
        yi    = int'(y);
        case (o)
            2'b00: e.z = 16'(py + px);
            2'b01: e.z = 16'(py - px);
            2'b10: begin
                e.z  = 16'(py * px);
                prev = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    lat += (y[i] != prev) ? 3 : 2;
                    prev = y[i];
                end
            end
            default: begin
                if (xi == 0) begin
                    e.err = 1'b1;
                end else begin
                    e.z = {8'(yi % xi), 8'(yi / xi)};
                    r = 0;
                    for (int i = 7; i >= 0; i--) begin
                        r = 2 * r + int'(y[i]);
                        if (r >= xi) begin
                            r   -= xi;
                            lat += 3;
                        end else begin
                            lat += 4;
                        end
                    end
                end
            end
        endcase
        e.done_cyc = now + lat;
        return e;
    endfunction

    int c4_cnt = 0;
    int c2_cnt = 0;

    // Monitor: per-cycle strobe rules and, on done, a scoreboard pop and compare.
    always @(negedge clk) begin
        if (!rst) begin
            c4_cnt = 0;
            c2_cnt = 0;
        end else begin
            if (c4 || c5) check("c5_eq_c4", 32'(c5), 32'(c4));
            if (c4 && op_q == 2'b10) check("c6_eq_a7", 32'(c6), 32'(a7));
            if (c4) c4_cnt++;
            if (c2) c2_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done with empty scoreboard at t=%0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("latency", 32'(cyc), 32'(mon_e.done_cyc));
                    check("busy_in_done", 32'(busy), 32'd1);
                    check("op_q", 32'(op_q), 32'(mon_e.op));
                    check("div_err", 32'(div_err), 32'(mon_e.err));
                    check("c7_done", 32'(c7), 32'(!mon_e.err));
                    check("c3_done", 32'(c3), 32'(mon_e.op == 2'b01));
                    check("c4_count", 32'(c4_cnt), (mon_e.op[1] && !mon_e.err) ? 32'd8 : 32'd0);
                    if (mon_e.op == 2'b11 && mon_e.err) begin
                        check("c2_count_div0", 32'(c2_cnt), 32'd0);
                    end else if (mon_e.op == 2'b11) begin
                        check("quotient", 32'({z[6:0], q_lsb}), 32'(mon_e.z[7:0]));
                        check("remainder", 32'(z[15:8]), 32'(mon_e.z[15:8]));
                    end else begin
                        check("z", 32'(z), 32'(mon_e.z));
                    end
                end
                c4_cnt = 0;
                c2_cnt = 0;
            end
        end
    end

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 80) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no done within 80 cycles");
            sb.delete();
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        cur_x = x;
        cur_y = y;
        op    = o;
        start = 1'b1;
        sb.push_back(model(o, x, y, cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        issue(o, x, y);
        wait_drain();
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({c0, c1, c2, c3, c4, c5, c6, c7, op_q, sel_in, busy, done, div_err, q_lsb}),
              32'd0);
    endtask

    initial begin
        logic [1:0] ro;
        logic [7:0] rx, ry;
        int         k, seen;

        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b1;

        run_op(2'b00, 8'd5, 8'd9);
        run_op(2'b01, 8'd9, 8'd5);
        run_op(2'b10, 8'hFD, 8'd7);
        run_op(2'b11, 8'd7, 8'd200);
        run_op(2'b11, 8'd0, 8'd50);
        run_op(2'b10, 8'h7F, 8'h80);
        run_op(2'b11, 8'd1, 8'd255);
        run_op(2'b11, 8'd127, 8'd0);

        // start while busy must not disturb the running multiply
        issue(2'b10, 8'd11, 8'hA5);
        repeat (4) @(negedge clk);
        op    = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // start during DONE must be ignored
        issue(2'b00, 8'd3, 8'd4);
        k = 0;
        while (!done && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(done), 32'd1);
        op    = 2'b10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_in_done_ignored", 32'(busy), 32'd0);
        wait_drain();

        // reset after the 4th c4 pulse of a multiply
        issue(2'b10, 8'hFD, 8'd7);
        seen = (c4 === 1'b1) ? 1 : 0;
        k    = 0;
        while (seen < 4 && k < 40) begin
            @(negedge clk);
            if (c4) seen++;
            k++;
        end
        check("c4_pulses_before_reset", 32'(seen), 32'd4);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("mid_op_reset_outputs");
        sb.delete();
        rst = 1'b1;

        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            rx = 8'($urandom);
            ry = 8'($urandom);
            if (ro == 2'b10 && rx == 8'h80) rx = 8'h7F;
            if (ro == 2'b11) rx = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
            run_op(ro, rx, ry);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
